// File: rtl/signed_divider_sat.sv
// signed_divider_sat: iterative restoring signed divider with saturation.
// Accepts dividend/divisor over valid/ready, produces one quotient bit per
// cycle from the operand magnitudes, then applies the sign fixup. Divide by
// zero and MIN/-1 are flagged at capture and saturate the result.
// Optional build macro: SIGNED_DIV_FAST_EXIT_EN, which lets the special cases
// bypass the iteration so their result is ready one cycle after capture.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | N restoring steps, then one fixup edge that registers the result
// DONE  | result presented, waiting for out_ready
module signed_divider_sat #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ov,
  output logic         uv,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  mag_b_q, mag_b_d;
  // Holds the dividend magnitude; quotient bits shift in from the LSB side.
  logic [N-1:0]  quo_q, quo_d;
  logic [N:0]    rem_q, rem_d;
  logic          is_dz_q, is_dz_d;
  logic          is_mm_q, is_mm_d;

  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          ov_q, ov_d;
  logic          uv_q, uv_d;
  logic          dz_q, dz_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [N-1:0]  abs_a;
  logic [N-1:0]  abs_b;
  logic          cap_dz;
  logic          cap_mm;
  logic [N:0]    shifted;
  logic [N+1:0]  diff;
  logic [N-1:0]  q_neg;
  logic [N-1:0]  r_neg;

  // |MIN| = 2^(N-1) is representable as an N-bit unsigned magnitude.
  assign abs_a  = a[N-1] ? (~a + 1'b1) : a;
  assign abs_b  = b[N-1] ? (~b + 1'b1) : b;
  assign cap_dz = (b == '0);
  assign cap_mm = (a == MIN_VAL) && (b == {N{1'b1}});

  // One restoring step: bring in the next dividend bit and trial-subtract.
  assign shifted = {rem_q[N-1:0], quo_q[N-1]};
  assign diff    = {1'b0, shifted} - {2'b00, mag_b_q};
  assign q_neg   = ~quo_q + 1'b1;
  assign r_neg   = ~rem_q[N-1:0] + 1'b1;

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      a_q         <= '0;
      mag_b_q     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      is_dz_q     <= 1'b0;
      is_mm_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ov_q        <= 1'b0;
      uv_q        <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      a_q         <= a_d;
      mag_b_q     <= mag_b_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      is_dz_q     <= is_dz_d;
      is_mm_q     <= is_mm_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ov_q        <= ov_d;
      uv_q        <= uv_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state, capture, iteration and fixup.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    a_d         = a_q;
    mag_b_d     = mag_b_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    is_dz_d     = is_dz_q;
    is_mm_d     = is_mm_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ov_d        = ov_q;
    uv_d        = uv_q;
    dz_d        = dz_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sa_d    = a[N-1];
          sb_d    = b[N-1];
          a_d     = a;
          mag_b_d = abs_b;
          quo_d   = abs_a;
          rem_d   = '0;
          is_dz_d = cap_dz;
          is_mm_d = cap_mm;
          cnt_d   = CW'(N);
`ifdef SIGNED_DIV_FAST_EXIT_EN
          // Special results are known already; go straight to the fixup edge.
          if (cap_dz || cap_mm) begin
            cnt_d = '0;
          end
`endif
          state_d = CALC;
        end
      end

      CALC: begin
        if (cnt_q == '0) begin
          ov_d = 1'b0;
          uv_d = 1'b0;
          dz_d = 1'b0;
          if (is_dz_q) begin
            dz_d        = 1'b1;
            remainder_d = a_q;
            if (sa_q) begin
              quotient_d = MIN_VAL;
              uv_d       = 1'b1;
            end else begin
              quotient_d = MAX_VAL;
              ov_d       = 1'b1;
            end
          end else if (is_mm_q) begin
            quotient_d  = MAX_VAL;
            remainder_d = '0;
            ov_d        = 1'b1;
          end else begin
            // |q| = 2^(N-1) only occurs with a negative result, so -qmag wraps to MIN.
            quotient_d  = (sa_q ^ sb_q) ? q_neg : quo_q;
            remainder_d = sa_q ? r_neg : rem_q[N-1:0];
          end
          state_d = DONE;
        end else begin
          if (!diff[N+1]) begin
            rem_d = diff[N:0];
            quo_d = {quo_q[N-2:0], 1'b1};
          end else begin
            rem_d = shifted;
            quo_d = {quo_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered from the next state so they stay low in reset.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ov        = ov_q;
  assign uv        = uv_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_signed_divider_sat.sv
// Directed bench for signed_divider_sat at N=8 with hand-computed vectors.
module tb_signed_divider_sat;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       ov;
  logic       uv;
  logic       dz;

  int checks = 0;
  int errors = 0;

`ifdef SIGNED_DIV_FAST_EXIT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 9;
`endif
  localparam int NORMAL_LAT = 9;

  signed_divider_sat #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ov        (ov),
    .uv        (uv),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble a/b after accept, measure latency, optionally
  // stall in DONE for 'hold' cycles, then complete the handshake.
  task automatic do_op(input int av, input int bv, input int eq, input int er,
                       input logic eov, input logic euv, input logic edz,
                       input int elat, input int hold);
    int lat;
    logic [7:0] eq8;
    logic [7:0] er8;
    eq8 = 8'(eq);
    er8 = 8'(er);
    @(negedge clk);
    a = 8'(av);
    b = 8'(bv);
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'(0));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("quotient", 32'(quotient), 32'(eq8));
    check("remainder", 32'(remainder), 32'(er8));
    check("ov", 32'(ov), 32'(eov));
    check("uv", 32'(uv), 32'(euv));
    check("dz", 32'(dz), 32'(edz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_quotient", 32'(quotient), 32'(eq8));
      check("hold_remainder", 32'(remainder), 32'(er8));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'(0));
    check("post_in_ready", 32'(in_ready), 32'(1));
    check("post_quotient_held", 32'(quotient), 32'(eq8));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_flags", 32'({ov, uv, dz}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'(1));
    check("release_out_valid", 32'(out_valid), 32'(0));

    // Sign combinations.
    do_op(100, 7, 14, 2, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(-100, 7, -14, -2, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(100, -7, -14, 2, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(-100, -7, 14, -2, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);

    // MIN boundaries.
    do_op(-128, -1, 127, 0, 1'b1, 1'b0, 1'b0, SPECIAL_LAT, 0);
    do_op(-128, 1, -128, 0, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(-128, -128, 1, 0, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(127, -128, 0, 127, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(-128, 7, -18, -2, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);
    do_op(-1, 2, 0, -1, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);

    // Divide by zero.
    do_op(5, 0, 127, 5, 1'b1, 1'b0, 1'b1, SPECIAL_LAT, 0);
    do_op(-5, 0, -128, -5, 1'b0, 1'b1, 1'b1, SPECIAL_LAT, 0);
    do_op(0, 0, 127, 0, 1'b1, 1'b0, 1'b1, SPECIAL_LAT, 0);

    // Back-pressure: stall four cycles in DONE.
    do_op(100, 7, 14, 2, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 4);

    // Leave nonzero outputs and flags behind, then reset in the middle of CALC.
    do_op(5, 0, 127, 5, 1'b1, 1'b0, 1'b1, SPECIAL_LAT, 0);
    @(negedge clk);
    a = 8'd100;
    b = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(0));
    check("abort_quotient", 32'(quotient), 32'(0));
    check("abort_remainder", 32'(remainder), 32'(0));
    check("abort_flags", 32'({ov, uv, dz}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_in_ready", 32'(in_ready), 32'(1));
    check("abort_no_result", 32'(out_valid), 32'(0));
    do_op(50, 5, 10, 0, 1'b0, 1'b0, 1'b0, NORMAL_LAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
